// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package mem_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Port indices: CPU data port and the secondary (DMA / copier) master.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Default SRAM bus geometry.
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for a single-port async SRAM.
// Owns the active-low cs/we strobes, holds the bus stable for WAIT_STATES+1
// cycles per access and inserts one idle turnaround cycle between accesses.
// Optional macro MEM_ARB_FIXED_PRI_EN: port 0 always wins a simultaneous
// request; without it, simultaneous requests alternate (round-robin).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              cs,
  output logic              we,
  output logic              busy
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                last_grant_reg, last_grant_next;
  logic                owner_reg, owner_next;
  logic [ADDR_W-1:0]   a_reg, a_next;
  logic [DATA_W-1:0]   dout_reg, dout_next;
  logic                cs_reg, cs_next;
  logic                we_reg, we_next;
  logic [1:0]          gnt_reg, gnt_next;
  logic [1:0]          ack_reg, ack_next;
  logic [DATA_W-1:0]   rdata0_reg, rdata0_next;
  logic [DATA_W-1:0]   rdata1_reg, rdata1_next;
  logic                busy_reg, busy_next;
  logic                win;
  logic                win_wr;

  // Winner selection; only called when at least one request is present.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
`ifdef MEM_ARB_FIXED_PRI_EN
    // Port 0 has absolute priority; last grant is tracked but not consulted.
    pick_winner = r0 ? PORT_CPU : PORT_AUX;
    if (last) begin end
`else
    // Round-robin: on a tie the port that was not served last wins.
    if (r0 && r1) pick_winner = ~last;
    else          pick_winner = r1 ? PORT_AUX : PORT_CPU;
`endif
  endfunction

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    a_next          = a_reg;
    dout_next       = dout_reg;
    cs_next         = cs_reg;
    we_next         = we_reg;
    gnt_next        = 2'b00;
    ack_next        = 2'b00;
    rdata0_next     = rdata0_reg;
    rdata1_next     = rdata1_reg;
    win             = PORT_CPU;
    win_wr          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (p0_req || p1_req) begin
          win             = pick_winner(p0_req, p1_req, last_grant_reg);
          win_wr          = win ? p1_we : p0_we;
          owner_next      = win;
          last_grant_next = win;
          a_next          = win ? p1_addr : p0_addr;
          // Reads leave the write-data bus where it was.
          if (win_wr) dout_next = win ? p1_wdata : p0_wdata;
          we_next         = ~win_wr;
          cs_next         = 1'b0;
          gnt_next[win]   = 1'b1;
          cnt_next        = WAIT_CNT;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          // we_reg high here means the access in flight is a read.
          if (we_reg) begin
            if (owner_reg) rdata1_next = data_in;
            else           rdata0_next = data_in;
          end
          cs_next              = 1'b1;
          we_next              = 1'b1;
          ack_next[owner_reg]  = 1'b1;
          state_next           = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      last_grant_reg <= PORT_AUX;
      owner_reg      <= PORT_CPU;
      a_reg          <= '0;
      dout_reg       <= '0;
      cs_reg         <= 1'b1;
      we_reg         <= 1'b1;
      gnt_reg        <= 2'b00;
      ack_reg        <= 2'b00;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      a_reg          <= a_next;
      dout_reg       <= dout_next;
      cs_reg         <= cs_next;
      we_reg         <= we_next;
      gnt_reg        <= gnt_next;
      ack_reg        <= ack_next;
      rdata0_reg     <= rdata0_next;
      rdata1_reg     <= rdata1_next;
      busy_reg       <= busy_next;
    end
  end

  assign A        = a_reg;
  assign data_out = dout_reg;
  assign cs       = cs_reg;
  assign we       = we_reg;
  assign busy     = busy_reg;
  assign p0_gnt   = gnt_reg[0];
  assign p1_gnt   = gnt_reg[1];
  assign p0_ack   = ack_reg[0];
  assign p1_ack   = ack_reg[1];
  assign p0_rdata = rdata0_reg;
  assign p1_rdata = rdata1_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one instance with
// WAIT_STATES=1 for the main sequences and one with WAIT_STATES=0.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

`ifdef MEM_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // Instance with WAIT_STATES=1
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p1_addr, A;
  logic [7:0]  p0_wdata, p1_wdata, p0_rdata, p1_rdata, data_out, data_in;
  logic        p0_gnt, p0_ack, p1_gnt, p1_ack, cs, we, busy;

  // Instance with WAIT_STATES=0
  logic        q0_req, q0_we, q1_req, q1_we;
  logic [15:0] q0_addr, q1_addr, qA;
  logic [7:0]  q0_wdata, q1_wdata, q0_rdata, q1_rdata, qdata_out, qdata_in;
  logic        q0_gnt, q0_ack, q1_gnt, q1_ack, qcs, qwe, qbusy;

  // SRAM read model: byte value is the low address byte XOR 0x68.
  assign data_in  = A[7:0]  ^ 8'h68;
  assign qdata_in = qA[7:0] ^ 8'h68;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .A(A), .data_out(data_out), .data_in(data_in),
    .cs(cs), .we(we), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .p0_req(q0_req), .p0_we(q0_we), .p0_addr(q0_addr), .p0_wdata(q0_wdata),
    .p0_gnt(q0_gnt), .p0_ack(q0_ack), .p0_rdata(q0_rdata),
    .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
    .p1_gnt(q1_gnt), .p1_ack(q1_ack), .p1_rdata(q1_rdata),
    .A(qA), .data_out(qdata_out), .data_in(qdata_in),
    .cs(qcs), .we(qwe), .busy(qbusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant pulse on the WAIT_STATES=1 instance.
  task automatic wait_gnt();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = p0_gnt | p1_gnt;
    end
    check("gnt_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      tick();
      idle = !busy;
    end
    check("idle_seen", 32'(idle), 32'd1);
  endtask

  initial begin
    int  last_cyc;
    int  exp_p1;
    bit  saw_p0_ack, got_ack;

    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    q0_req = 0; q0_we = 0; q0_addr = '0; q0_wdata = '0;
    q1_req = 0; q1_we = 0; q1_addr = '0; q1_wdata = '0;

    // Reset values
    repeat (2) tick();
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_we", 32'(we), 32'd1);
    check("rst_A", 32'(A), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", {p1_gnt, p0_gnt, p1_ack, p0_ack}, 32'd0);
    check("rst_rdata", {p1_rdata, p0_rdata}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Port 0 write 0x0012 <= 0xA5
    p0_req = 1; p0_we = 1; p0_addr = 16'h0012; p0_wdata = 8'hA5;
    tick();
    $display("txn p0 write A=%h d=%h gnt=%0d", A, data_out, p0_gnt);
    check("w_gnt", 32'(p0_gnt), 32'd1);
    check("w_p1gnt", 32'(p1_gnt), 32'd0);
    check("w_cs0", {cs, we}, 32'd0);
    check("w_A", 32'(A), 32'h0012);
    check("w_dout", 32'(data_out), 32'hA5);
    check("w_busy", 32'(busy), 32'd1);
    p0_req = 0; p0_we = 0; p0_addr = 16'hFFFF; p0_wdata = 8'h00;
    tick();
    check("w_gnt_pulse", 32'(p0_gnt), 32'd0);
    check("w_cs1", {cs, we}, 32'd0);
    check("w_ack_early", 32'(p0_ack), 32'd0);
    check("w_A_hold", 32'(A), 32'h0012);
    tick();
    check("w_ack", 32'(p0_ack), 32'd1);
    check("w_cs_rel", {cs, we}, 32'd3);
    tick();
    check("w_ack_pulse", 32'(p0_ack), 32'd0);
    check("w_idle", 32'(busy), 32'd0);

    // Port 1 read 0x0034 -> 0x5C
    p1_req = 1; p1_we = 0; p1_addr = 16'h0034;
    tick();
    $display("txn p1 read A=%h gnt=%0d", A, p1_gnt);
    check("r_gnt", 32'(p1_gnt), 32'd1);
    check("r_p0gnt", 32'(p0_gnt), 32'd0);
    check("r_cs_we", {cs, we}, 32'd1);
    check("r_dout_hold", 32'(data_out), 32'hA5);
    p1_req = 0;
    tick();
    check("r_ack_early", 32'(p1_ack), 32'd0);
    tick();
    $display("txn p1 read ack=%0d rdata=%h", p1_ack, p1_rdata);
    check("r_ack", 32'(p1_ack), 32'd1);
    check("r_rdata", 32'(p1_rdata), 32'h5C);
    check("r_p0ack", 32'(p0_ack), 32'd0);
    check("r_p0rdata", 32'(p0_rdata), 32'd0);
    tick();

    // WAIT_STATES=0: port 0 read 0x0077 -> 0x1F, request held
    q0_req = 1; q0_we = 0; q0_addr = 16'h0077;
    tick();
    check("z_gnt", 32'(q0_gnt), 32'd1);
    check("z_cs", 32'(qcs), 32'd0);
    tick();
    $display("txn ws0 read ack=%0d rdata=%h", q0_ack, q0_rdata);
    check("z_cs_one", 32'(qcs), 32'd1);
    check("z_ack", 32'(q0_ack), 32'd1);
    check("z_rdata", 32'(q0_rdata), 32'h1F);
    tick();
    check("z_no_gnt_gap", 32'(q0_gnt), 32'd0);
    tick();
    check("z_regnt", 32'(q0_gnt), 32'd1);
    q0_req = 0;
    repeat (3) tick();

    // Both ports requesting continuously from reset
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    p0_req = 1; p0_we = 0; p0_addr = 16'h0100;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0200;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      exp_p1 = (k == 4) ? 1 : (FIXED ? 0 : (k % 2));
      $display("txn both k=%0d p0_gnt=%0d p1_gnt=%0d cyc=%0d", k, p0_gnt, p1_gnt, cyc);
      check("rr_p1gnt", 32'(p1_gnt), 32'(exp_p1));
      check("rr_p0gnt", 32'(p0_gnt), 32'(1 - exp_p1));
      if (k > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd4);
      last_cyc = cyc;
      if (k == 3) p0_req = 0;
      if (k == 4) p1_req = 0;
    end
    wait_idle();

    // Reset asserted mid-ACCESS
    p0_req = 1; p0_we = 1; p0_addr = 16'h0055; p0_wdata = 8'h3C;
    tick();
    check("m_gnt", 32'(p0_gnt), 32'd1);
    p0_req = 0;
    #2 rst = 1'b1;
    #1;
    $display("txn mid-access reset cs=%0d we=%0d A=%h", cs, we, A);
    check("m_cs", 32'(cs), 32'd1);
    check("m_we", 32'(we), 32'd1);
    check("m_A", 32'(A), 32'd0);
    check("m_dout", 32'(data_out), 32'd0);
    check("m_gnt_ack", {p0_gnt, p0_ack, p1_gnt, p1_ack}, 32'd0);
    check("m_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    @(negedge clk) rst = 1'b0;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0001;
    saw_p0_ack = 0; got_ack = 0;
    for (int i = 0; i < 12 && !got_ack; i++) begin
      tick();
      if (p0_ack) saw_p0_ack = 1;
      if (p1_gnt) p1_req = 0;
      if (p1_ack) begin
        got_ack = 1;
        $display("txn post-reset p1 read rdata=%h", p1_rdata);
        check("m_rdata", 32'(p1_rdata), 32'h69);
      end
    end
    check("m_p1_ack", 32'(got_ack), 32'd1);
    check("m_no_p0_ack", 32'(saw_p0_ack), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
